fp_compare_pipe: RTL and testbench



---
 rtl/fp_compare_pipe.sv | 114 +++++++++++
 tb/tb_fp_compare_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: 2-stage multi-lane FloPoCo comparator with ready/valid; FP_CMP_STATS_EN adds stat_unordered_cnt
module fp_compare_pipe #(
  parameter int WE = 11,
  parameter int WF = 15,
  parameter int LANES = 3,
  parameter int TAG_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_op,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [LANES*(WE+WF+3)-1:0]    in_a,
  input  logic [LANES*(WE+WF+3)-1:0]    in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0]              out_result,
  output logic [LANES-1:0]              out_unordered,
  output logic [TAG_W-1:0]              out_tag
`ifdef FP_CMP_STATS_EN
  ,
  output logic [15:0]                   stat_unordered_cnt
`endif
);
  localparam int W = WE + WF + 3;
  logic adv, v1;
  logic [W-1:0] a [LANES];
  logic [W-1:0] b [LANES];
  logic [LANES-1:0] lt0, eq0, sa0, sb0, un0;
  logic [LANES-1:0] lt1, eq1, sa1, sb1, un1;
  logic [LANES-1:0] lt2, eq2, res;
  logic [2:0] op1;
  logic [TAG_W-1:0] tag1;
  // exponent/fraction only count for normals, so garbage in zero/inf fields compares equal
  function automatic logic [W-2:0] key(input logic [W-1:0] x);
    return {x[W-1:W-2], x[W-1:W-2] == 2'b01 ? x[W-4:0] : {(W-3){1'b0}}};
  endfunction
  genvar i;
  for (i = 0; i < LANES; i++) begin : g_lane
    assign a[i] = in_a[i*W +: W];
    assign b[i] = in_b[i*W +: W];
  end
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  always_comb begin
    lt0 = '0;
    eq0 = '0;
    sa0 = '0;
    sb0 = '0;
    un0 = '0;
    for (int j = 0; j < LANES; j++) begin
      lt0[j] = key(a[j]) < key(b[j]);
      eq0[j] = key(a[j]) == key(b[j]);
      sa0[j] = a[j][W-3] & |a[j][W-1:W-2];
      sb0[j] = b[j][W-3] & |b[j][W-1:W-2];
      un0[j] = &a[j][W-1:W-2] | &b[j][W-1:W-2];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else if (adv) begin
      v1 <= in_valid;
      lt1 <= lt0;
      eq1 <= eq0;
      sa1 <= sa0;
      sb1 <= sb0;
      un1 <= un0;
      op1 <= in_op;
      tag1 <= in_tag;
    end
  end
  // both negative flips magnitude order; differing signs make the negative one smaller
  always_comb begin
    lt2 = '0;
    eq2 = '0;
    res = '0;
    for (int j = 0; j < LANES; j++) begin
      lt2[j] = sa1[j] != sb1[j] ? sa1[j] : sa1[j] ? !(lt1[j] | eq1[j]) : lt1[j];
      eq2[j] = sa1[j] == sb1[j] && eq1[j];
      res[j] = un1[j] ? op1 == 3'd1 :
               op1 == 3'd0 ? eq2[j] :
               op1 == 3'd1 ? !eq2[j] :
               op1 == 3'd2 ? lt2[j] :
               op1 == 3'd3 ? lt2[j] | eq2[j] :
               op1 == 3'd4 ? !(lt2[j] | eq2[j]) :
               op1 == 3'd5 ? !lt2[j] : 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_result <= '0;
      out_unordered <= '0;
      out_tag <= '0;
    end else if (adv) begin
      out_valid <= v1;
      out_result <= res;
      out_unordered <= un1;
      out_tag <= tag1;
    end
  end
`ifdef FP_CMP_STATS_EN
  logic [16:0] sum;
  always_comb begin
    sum = {1'b0, stat_unordered_cnt};
    for (int j = 0; j < LANES; j++) sum = sum + 17'(out_unordered[j]);
  end
  always_ff @(posedge clk) begin
    if (rst) stat_unordered_cnt <= '0;
    else if (out_valid && out_ready) stat_unordered_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
  end
`endif
endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: scoreboard bench with a numeric-rank reference model for fp_compare_pipe
module tb_fp_compare_pipe;
  localparam int WE = 11, WF = 15, LANES = 3, TAG_W = 8, W = WE + WF + 3;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [2:0] in_op = 0;
  logic [TAG_W-1:0] in_tag = 0, out_tag;
  logic [LANES*W-1:0] in_a = 0, in_b = 0;
  logic [LANES-1:0] out_result, out_unordered;
`ifdef FP_CMP_STATS_EN
  logic [15:0] stat;
  longint mcnt = 0;
`endif

  fp_compare_pipe #(.WE(WE), .WF(WF), .LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_unordered(out_unordered), .out_tag(out_tag)
`ifdef FP_CMP_STATS_EN
    , .stat_unordered_cnt(stat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] res;
    logic [LANES-1:0] un;
    logic [TAG_W-1:0] tag;
    int acc;
    bit lat;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0, mode = 0, stall_at = -100;
  logic [7:0] tagc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // signed numeric rank: -0 and +0 collapse, zero < normal < inf
  function automatic longint rank(input logic [W-1:0] x);
    longint mag;
    case (x[W-1:W-2])
      2'b00: mag = 0;
      2'b01: mag = 1 + longint'(x[W-4:0]);
      default: mag = (64'sd1 <<< (W - 3)) + 1;
    endcase
    return (x[W-3] && x[W-1:W-2] != 2'b00) ? -mag : mag;
  endfunction

  function automatic bit model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ra, rb;
    ra = rank(a);
    rb = rank(b);
    if (a[W-1:W-2] == 2'b11 || b[W-1:W-2] == 2'b11) return op == 3'd1;
    case (op)
      3'd0: return ra == rb;
      3'd1: return ra != rb;
      3'd2: return ra < rb;
      3'd3: return ra <= rb;
      3'd4: return ra > rb;
      3'd5: return ra >= rb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [LANES*W-1:0] rep(input logic [W-1:0] x);
    return {LANES{x}};
  endfunction

  task automatic send(input logic [2:0] op, input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b);
    exp_t e;
    tagc = tagc + 1;
    in_valid = 1;
    in_op = op;
    in_tag = tagc;
    in_a = a;
    in_b = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = '0;
        e.un = '0;
        for (int i = 0; i < LANES; i++) begin
          e.res[i] = model(op, a[i*W +: W], b[i*W +: W]);
          e.un[i] = a[i*W+W-2 +: 2] == 2'b11 || b[i*W+W-2 +: 2] == 2'b11;
        end
        e.tag = tagc;
        e.acc = cyc;
        e.lat = mode == 0;
        q.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    in_op = 3'($urandom);
    in_a = {3{$urandom}};
    in_b = {3{$urandom}};
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [1:0] e;
    logic [W-4:0] f;
    int r;
    r = $urandom_range(0, 5);
    e = r == 0 ? 2'b00 : r <= 3 ? 2'b01 : r == 4 ? 2'b10 : 2'b11;
    f = (W-3)'($urandom);
    if ($urandom_range(0, 3) == 0) f[3:0] = 4'h0;
    return {e, 1'($urandom), f};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = mode == 1 ? $urandom_range(0, 3) != 0 :
                  mode == 2 ? !(cyc >= stall_at && cyc < stall_at + 3) : 1'b1;
    end
  end

  logic held_v = 0;
  logic [2*LANES+TAG_W-1:0] held;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 0;
`ifdef FP_CMP_STATS_EN
        mcnt = 0;
`endif
      end else begin
        check("in_ready", in_ready, !out_valid || out_ready);
        if (held_v) check("hold_stable", {out_valid, out_result, out_unordered, out_tag}, {1'b1, held});
        held_v = out_valid && !out_ready;
        held = {out_result, out_unordered, out_tag};
`ifdef FP_CMP_STATS_EN
        check("stat_cnt", stat, mcnt);
`endif
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: tag %0h emitted with empty scoreboard", out_tag);
          end else begin
            e = q.pop_front();
            check("result", out_result, e.res);
            check("unordered", out_unordered, e.un);
            check("tag", out_tag, e.tag);
            if (e.lat) check("latency", cyc - e.acc, 2);
`ifdef FP_CMP_STATS_EN
            mcnt = mcnt + $countones(e.un);
            if (mcnt > 16'hFFFF) mcnt = 16'hFFFF;
`endif
          end
        end
      end
    end
  end

  initial begin
    logic [LANES*W-1:0] a, b;
    logic [W-1:0] x;
    int r;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_result", out_result, 0);
    check("reset_unordered", out_unordered, 0);
    check("reset_tag", out_tag, 0);
    rst = 0;
    idle(2);
    send(3'd5, {29'h0A000000, 29'h0DFF8000, 29'h09FF8000}, rep(29'h09FF8000));
    idle(3);
    send(3'd0, rep(29'h00000000), rep(29'h04000000));
    send(3'd2, rep(29'h0DFF8000), rep(29'h04000000));
    for (int o = 0; o < 6; o++) send(3'(o), rep(29'h18000000), rep(29'h09FF8000));
    send(3'd0, rep(29'h10001234), rep(29'h10000000));
    send(3'd4, rep(29'h10000000), rep(29'h0A000000));
    send(3'd6, rep(29'h18000000), rep(29'h09FF8000));
    send(3'd7, rep(29'h09FF8000), rep(29'h09FF8000));
    idle(4);
    mode = 2;
    stall_at = cyc + 3;
    for (int t = 0; t < 6; t++) send(3'(t), {rnd_op(), rnd_op(), rnd_op()}, {rnd_op(), rnd_op(), rnd_op()});
    idle(8);
    mode = 0;
    idle(2);
    send(3'd1, rep(29'h09FF8000), rep(29'h0A000000));
    send(3'd3, rep(29'h09FF8000), rep(29'h0A000000));
    in_valid = 0;
    rst = 1;
    q.delete();
    @(posedge clk);
    #1;
    check("rst_mid_valid", out_valid, 0);
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      check("post_rst_idle", out_valid, 0);
    end
    mode = 1;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        for (int i = 0; i < LANES; i++) begin
          x = rnd_op();
          a[i*W +: W] = x;
          r = $urandom_range(0, 3);
          b[i*W +: W] = r == 0 ? x : r == 1 ? x ^ (29'd1 << (W - 3)) : r == 2 ? x ^ 29'd1 : rnd_op();
        end
        send(3'($urandom_range(0, 7)), a, b);
      end
    end
    mode = 0;
    idle(12);
    check("drain_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
